// File: rtl/avr_pkg.sv
// Shared definitions for the AVR control-flow slice: PC select codes,
// opcode mask/match pairs and the flow-control state encoding.
package avr_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_SRC_W = 3;

  localparam logic [PC_SRC_W-1:0] PC_SRC_INC  = 3'b000;
  localparam logic [PC_SRC_W-1:0] PC_SRC_HOLD = 3'b010;
  localparam logic [PC_SRC_W-1:0] PC_SRC_REL  = 3'b100;
  localparam logic [PC_SRC_W-1:0] PC_SRC_ABS  = 3'b101;

  localparam logic [INSTR_W-1:0] RJMP_MASK  = 16'hF000;
  localparam logic [INSTR_W-1:0] RJMP_MATCH = 16'hC000;
  localparam logic [INSTR_W-1:0] BRBX_MASK  = 16'hF800;
  localparam logic [INSTR_W-1:0] BRBX_MATCH = 16'hF000;
  localparam logic [INSTR_W-1:0] JMP_MASK   = 16'hFE0E;
  localparam logic [INSTR_W-1:0] JMP_MATCH  = 16'h940C;
  localparam logic [INSTR_W-1:0] CALL_MATCH = 16'h940E;
  localparam logic [INSTR_W-1:0] LDS_MASK   = 16'hFE0F;
  localparam logic [INSTR_W-1:0] LDS_MATCH  = 16'h9000;
  localparam logic [INSTR_W-1:0] STS_MATCH  = 16'h9200;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_JMP2  = 2'd1,
    ST_SKIP2 = 2'd2,
    ST_FLUSH = 2'd3
  } flow_state_e;

endpackage

// File: rtl/avr_instr_class.sv
// Combinational classifier: flags the control-flow relevant opcode groups
// and extracts the branch offset / status-bit fields.
module avr_instr_class
  import avr_pkg::*;
(
  input  logic [15:0] instr,
  output logic        is_rjmp,
  output logic        is_brbx,
  output logic        is_jmp_call,
  output logic        is_two_word,
  output logic [11:0] k12,
  output logic [6:0]  k7,
  output logic [2:0]  s,
  output logic        x
);

  logic is_lds_sts;

  always_comb begin
    is_rjmp     = (instr & RJMP_MASK) == RJMP_MATCH;
    is_brbx     = (instr & BRBX_MASK) == BRBX_MATCH;
    is_jmp_call = ((instr & JMP_MASK) == JMP_MATCH) || ((instr & JMP_MASK) == CALL_MATCH);
    is_lds_sts  = ((instr & LDS_MASK) == LDS_MATCH) || ((instr & LDS_MASK) == STS_MATCH);
    is_two_word = is_jmp_call || is_lds_sts;
    k12         = instr[11:0];
    k7          = instr[9:3];
    s           = instr[2:0];
    x           = instr[10];
  end

endmodule

// File: rtl/avr_flow_ctl.sv
// Consumer-side control-flow unit: picks the next PC source for fetch and
// forwards a registered, validated instruction stream to execute.
module avr_flow_ctl
  import avr_pkg::*;
#(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned SREG_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       cur_instr,
  input  logic [SREG_W-1:0] sreg,
  input  logic              stall_req,
  input  logic              skip_req,
  output logic [2:0]        pc_src,
  output logic [PC_W-1:0]   jmp,
  output logic [15:0]       exec_instr,
  output logic              exec_valid,
  output logic              exec_word2
);

  flow_state_e state_q, state_d;
  logic        word2_pend_q, word2_pend_d;
  logic [15:0] exec_instr_d;
  logic        exec_valid_d, exec_word2_d;

  logic        is_rjmp, is_brbx, is_jmp_call, is_two_word, x;
  logic [11:0] k12;
  logic [6:0]  k7;
  logic [2:0]  s;
  logic        br_taken;

  avr_instr_class u_class (
    .instr       (cur_instr),
    .is_rjmp     (is_rjmp),
    .is_brbx     (is_brbx),
    .is_jmp_call (is_jmp_call),
    .is_two_word (is_two_word),
    .k12         (k12),
    .k7          (k7),
    .s           (s),
    .x           (x)
  );

  assign br_taken = is_brbx && (sreg[s] == ~x);

  // Next state, PC select and exec pipeline inputs; priority RST > stall > skip > decode.
  always_comb begin
    state_d      = state_q;
    word2_pend_d = word2_pend_q;
    pc_src       = PC_SRC_INC;
    jmp          = '0;
    exec_instr_d = cur_instr;
    exec_valid_d = 1'b0;
    exec_word2_d = 1'b0;

    if (RST) begin
      pc_src       = PC_SRC_HOLD;
      state_d      = ST_RUN;
      word2_pend_d = 1'b0;
      exec_instr_d = '0;
    end else if (stall_req) begin
      pc_src = PC_SRC_HOLD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (skip_req) begin
            word2_pend_d = 1'b0;
            state_d      = is_two_word ? ST_SKIP2 : ST_RUN;
          end else if (word2_pend_q) begin
            // LDS/STS address word: pass through untouched, never decoded
            exec_valid_d = 1'b1;
            exec_word2_d = 1'b1;
            word2_pend_d = 1'b0;
          end else begin
            exec_valid_d = 1'b1;
            if (is_rjmp) begin
              pc_src  = PC_SRC_REL;
              jmp     = {{(PC_W-12){k12[11]}}, k12};
              state_d = ST_FLUSH;
            end else if (br_taken) begin
              pc_src  = PC_SRC_REL;
              jmp     = {{(PC_W-7){k7[6]}}, k7};
              state_d = ST_FLUSH;
            end else if (is_jmp_call) begin
              state_d = ST_JMP2;
            end else if (is_two_word) begin
              word2_pend_d = 1'b1;
            end
          end
        end
        ST_JMP2: begin
          pc_src       = PC_SRC_ABS;
          jmp          = PC_W'(cur_instr);
          exec_valid_d = 1'b1;
          exec_word2_d = 1'b1;
          state_d      = ST_FLUSH;
        end
        ST_SKIP2: state_d = ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_RUN;
      word2_pend_q <= 1'b0;
      exec_instr   <= '0;
      exec_valid   <= 1'b0;
      exec_word2   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word2_pend_q <= word2_pend_d;
      exec_instr   <= exec_instr_d;
      exec_valid   <= exec_valid_d;
      exec_word2   <= exec_word2_d;
    end
  end

endmodule

// File: tb/tb_avr_flow_ctl.sv
// Self-checking bench for avr_flow_ctl: table-driven steps, combinational
// outputs checked same cycle, exec_* expectations queued and popped a cycle later.
module tb_avr_flow_ctl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] cur_instr;
  logic [7:0]  sreg;
  logic        stall_req, skip_req;
  logic [2:0]  pc_src;
  logic [15:0] jmp;
  logic [15:0] exec_instr;
  logic        exec_valid, exec_word2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] ei;
    logic        v;
    logic        w2;
    logic        chk_i;
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] INC  = 3'b000;
  localparam logic [2:0] HOLD = 3'b010;
  localparam logic [2:0] REL  = 3'b100;
  localparam logic [2:0] ABS  = 3'b101;

  avr_flow_ctl #(.PC_W(16), .SREG_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cur_instr  (cur_instr),
    .sreg       (sreg),
    .stall_req  (stall_req),
    .skip_req   (skip_req),
    .pc_src     (pc_src),
    .jmp        (jmp),
    .exec_instr (exec_instr),
    .exec_valid (exec_valid),
    .exec_word2 (exec_word2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // One cycle: drive inputs, check pc_src/jmp, then check exec_* after the edge.
  task automatic step(input string tag, input logic r, input logic [15:0] i,
                      input logic [7:0] sr, input logic st, input logic sk,
                      input logic [2:0] ps, input logic [15:0] j,
                      input logic v, input logic w2, input logic [15:0] ei);
    exp_t e;
    @(negedge CLK);
    RST = r; cur_instr = i; sreg = sr; stall_req = st; skip_req = sk;
    #1;
    chk({tag, ".pc_src"}, 32'(pc_src), 32'(ps));
    chk({tag, ".jmp"}, 32'(jmp), 32'(j));
    e.ei = ei; e.v = v; e.w2 = w2; e.chk_i = v | r;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, ".exec_valid"}, 32'(exec_valid), 32'(e.v));
      chk({tag, ".exec_word2"}, 32'(exec_word2), 32'(e.w2));
      if (e.chk_i) chk({tag, ".exec_instr"}, 32'(exec_instr), 32'(e.ei));
    end
  endtask

  initial begin
    RST = 1'b1; cur_instr = '0; sreg = '0; stall_req = 1'b0; skip_req = 1'b0;
    //    tag          rst  instr     sreg   st  sk   pc_src jmp       v  w2 exec_instr
    step("rst0",       1, 16'h0000, 8'h00, 0, 0, HOLD, 16'h0000, 0, 0, 16'h0000);
    step("rst1",       1, 16'h1234, 8'h00, 0, 0, HOLD, 16'h0000, 0, 0, 16'h0000);
    step("nop0",       0, 16'h0000, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h0000);
    step("nop1",       0, 16'h0000, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h0000);
    // RJMP .-1 loops on itself
    step("rjmp_a",     0, 16'hCFFF, 8'h00, 0, 0, REL,  16'hFFFF, 1, 0, 16'hCFFF);
    step("rjmp_fl",    0, 16'hCFFF, 8'h00, 0, 0, INC,  16'h0000, 0, 0, 16'h0000);
    step("rjmp_b",     0, 16'hCFFF, 8'h00, 0, 0, REL,  16'hFFFF, 1, 0, 16'hCFFF);
    step("rjmp_fl2",   0, 16'h0000, 8'h00, 0, 0, INC,  16'h0000, 0, 0, 16'h0000);
    // JMP 0x0050
    step("jmp_w1",     0, 16'h940C, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h940C);
    step("jmp_w2",     0, 16'h0050, 8'h00, 0, 0, ABS,  16'h0050, 1, 1, 16'h0050);
    step("jmp_fl",     0, 16'h1234, 8'h00, 0, 0, INC,  16'h0000, 0, 0, 16'h0000);
    // BREQ +5 taken, then back-to-back branch word discarded in FLUSH
    step("breq_t",     0, 16'hF029, 8'h02, 0, 0, REL,  16'h0005, 1, 0, 16'hF029);
    step("breq_fl",    0, 16'hF029, 8'h02, 0, 0, INC,  16'h0000, 0, 0, 16'h0000);
    step("breq_nt",    0, 16'hF029, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'hF029);
    step("breq_nfl",   0, 16'h0000, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h0000);
    // BRNE .-1 (BRBC s=1) taken with Z=0, negative offset
    step("brne_t",     0, 16'hF7F9, 8'h00, 0, 0, REL,  16'hFFFF, 1, 0, 16'hF7F9);
    step("brne_fl",    0, 16'h0000, 8'h00, 0, 0, INC,  16'h0000, 0, 0, 16'h0000);
    // skip of a two-word instruction
    step("skip_w1",    0, 16'h940C, 8'h00, 0, 1, INC,  16'h0000, 0, 0, 16'h0000);
    step("skip_w2",    0, 16'h0050, 8'h00, 0, 0, INC,  16'h0000, 0, 0, 16'h0000);
    step("skip_done",  0, 16'h0000, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h0000);
    // LDS: address word passes through undecoded
    step("lds_w1",     0, 16'h9100, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h9100);
    step("lds_w2",     0, 16'hC123, 8'h00, 0, 0, INC,  16'h0000, 1, 1, 16'hC123);
    step("lds_after",  0, 16'h0000, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h0000);
    // stall in JMP2
    step("stj_w1",     0, 16'h940C, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h940C);
    step("stj_s0",     0, 16'h0050, 8'h00, 1, 0, HOLD, 16'h0000, 0, 0, 16'h0000);
    step("stj_s1",     0, 16'h0050, 8'h00, 1, 1, HOLD, 16'h0000, 0, 0, 16'h0000);
    step("stj_s2",     0, 16'h0050, 8'h00, 1, 0, HOLD, 16'h0000, 0, 0, 16'h0000);
    step("stj_w2",     0, 16'h0050, 8'h00, 0, 0, ABS,  16'h0050, 1, 1, 16'h0050);
    step("stj_fl",     0, 16'h0000, 8'h00, 0, 0, INC,  16'h0000, 0, 0, 16'h0000);
    // RST while in JMP2 aborts with no flush
    step("call_w1",    0, 16'h940E, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h940E);
    step("call_rst",   1, 16'h0050, 8'h00, 0, 0, HOLD, 16'h0000, 0, 0, 16'h0000);
    step("post_rst",   0, 16'h0050, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h0050);
    // skip_req ignored in FLUSH
    step("rjmp_p",     0, 16'hC005, 8'h00, 0, 0, REL,  16'h0005, 1, 0, 16'hC005);
    step("fl_skip",    0, 16'h940C, 8'h00, 0, 1, INC,  16'h0000, 0, 0, 16'h0000);
    step("fl_after",   0, 16'h0000, 8'h00, 0, 0, INC,  16'h0000, 1, 0, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
